ofs_plat_axi_stream_rr_arbiter: RTL and testbench
=================================================

# ofs_plat_axi_stream_rr_arbiter

Packet-granular round-robin arbiter that merges NUM_SOURCES AXI streams into one AXI stream, with one registered output stage. Used wherever several AFU engines share a single stream toward a host or memory channel. A grant is held until the owning source's last beat is accepted, so packets are never interleaved. The source index of every beat is forwarded on the sink so that responses can be routed back.

## Interface
Parameters:
- NUM_SOURCES, default 4: number of requesting streams; legal range 2–16.
- TDATA_WIDTH, default 512: payload width in bits.
- TUSER_WIDTH, default 16: user sideband width in bits.
- TID_WIDTH, default $clog2(NUM_SOURCES): width of the source index; derived, not overridden.

Ports:
- clk, input, 1: the single clock.
- reset, input, 1: asynchronous, active-high reset.
- src_tvalid, input, NUM_SOURCES: per-source valid.
- src_tready, output, NUM_SOURCES: per-source ready; one-hot or zero.
- src_tlast, input, NUM_SOURCES: per-source end of packet.
- src_tdata, input, NUM_SOURCES×TDATA_WIDTH: per-source payload; source i occupies slice i.
- src_tuser, input, NUM_SOURCES×TUSER_WIDTH: per-source user sideband.
- sink_tvalid, output, 1: merged stream valid.
- sink_tready, input, 1: merged stream ready.
- sink_tlast, output, 1: merged end of packet.
- sink_tdata, output, TDATA_WIDTH: merged payload.
- sink_tuser, output, TUSER_WIDTH: merged user sideband.
- sink_tid, output, TID_WIDTH: index of the source that produced the beat.
- pkt_active, output, 1: a multi-beat packet is locked in progress.

## Operation
- Output stage is a single register holding {last, user, data, tid} plus sink_tvalid.
  - can_accept = !sink_tvalid || sink_tready.
  - The register loads whenever a source beat is accepted.
  - sink_tvalid clears when sink_tready is high and no beat is accepted.
- The arbiter FSM has two states, ARB and LOCKED.
- In ARB:
  - grant = first i with src_tvalid[i], searching from ptr upward and wrapping modulo NUM_SOURCES.
  - src_tready[grant] = can_accept.
  - If the beat is accepted with tlast=1: stay in ARB and set ptr = (grant+1) mod NUM_SOURCES.
  - If the beat is accepted with tlast=0: go to LOCKED with owner = grant.
  - If no source is valid, or can_accept=0: no state change and ptr holds. A stalled grant may be re-evaluated the next cycle.
- In LOCKED:
  - Only src_tready[owner] may be asserted; it equals can_accept. All other sources wait regardless of their tvalid.
  - When a beat is accepted with tlast=1: go to ARB and set ptr = (owner+1) mod NUM_SOURCES.
- pkt_active = (state == LOCKED).
- Source handshakes:
  - A source beat is accepted when src_tvalid[i] && src_tready[i].
  - src_tready may depend combinationally on src_tvalid and on sink_tready.
  - Sources must hold tvalid and payload stable until accepted.
- Fairness: a continuously requesting source waits at most NUM_SOURCES−1 packets.

## Timing
- Reset values:
  - sink_tvalid=0, sink_tlast=0, sink_tdata=0, sink_tuser=0, sink_tid=0.
  - src_tready=0, pkt_active=0.
  - state=ARB, ptr=0, owner=0.
- Latency: a beat accepted at edge t is presented on the sink after edge t (1 cycle).
- Throughput is 1 beat per cycle sustained, including across packet boundaries.
  - In the last-beat cycle, the grant moves at that edge. The next owner's first beat is accepted the following cycle with no bubble.
- Backpressure:
  - While sink_tvalid && !sink_tready, all src_tready=0.
  - Sink outputs hold stable while stalled.
- Simultaneous sink drain and source accept in one cycle: the register is overwritten with the new beat and sink_tvalid stays 1.
- Reset asserted mid-packet: takes effect immediately.
  - The output register clears and the in-progress packet is abandoned.
  - Sources are reset by the same signal.
- ptr wraps from NUM_SOURCES−1 to 0.

## Structure
- Package ofs_plat_axi_stream_arb_pkg holds:
  - t_arb_state enum {ARB, LOCKED}.
  - Function rr_pick(req, ptr) returning {found, index}.
- One sub-module, ofs_plat_axi_stream_out_reg: the one-stage registered output. Parameterized by payload width; exposes can_accept.

## Test plan
- Single source: source 2 sends a 3-beat packet with data 0xA, 0xB, 0xC and sink_tready=1.
  - Sink shows 0xA, 0xB, 0xC on consecutive cycles, one cycle after each accept.
  - sink_tid=2 throughout; pkt_active=1 from the first accept until the last accept.
- All four sources continuously offer 1-beat packets with sink_tready=1 from reset: sink_tid sequence is 0,1,2,3,0,1,… with no gaps.
- Source 0 sends a 4-beat packet while source 1 is valid from cycle 1: source 1 receives no ready until source 0's last beat is accepted, and no source-1 beat is interleaved.
- sink_tready low for 5 cycles mid-packet:
  - All src_tready stay 0 and sink outputs hold stable.
  - On release the stream resumes with no beat lost or duplicated.
- Reset pulse while LOCKED on source 3: on the following edge sink_tvalid=0, pkt_active=0 and ptr=0.
- NUM_SOURCES=3: ptr wraps from 2 to 0.
- Random stimulus with a scoreboard: per-source packet order is preserved.
- Starvation check: no source waits more than NUM_SOURCES−1 packets.

Source files
------------

// File: rtl/ofs_plat_axi_stream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofs_plat_axi_stream_arb_pkg
// Description : Shared types and the round-robin pick helper used by the
//               packet-granular AXI stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ofs_plat_axi_stream_arb_pkg;

    // Upper bound on sources supported by the pick helper.
    localparam int c_MAX_SOURCES = 16;
    localparam int c_MAX_IDX_W   = 4;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } t_arb_state;

    typedef struct packed {
        logic                   found;
        logic [c_MAX_IDX_W-1:0] index;
    } t_rr_pick;

    // First requester at or after ptr, wrapping modulo num. The sum
    // ptr + k never exceeds 2*num-2, so a single conditional subtract
    // replaces a modulo operator.
    function automatic t_rr_pick rr_pick(
        input logic [c_MAX_SOURCES-1:0] req,
        input logic [c_MAX_IDX_W-1:0]   ptr,
        input int                       num
    );
        t_rr_pick             result;
        logic [c_MAX_IDX_W:0] idx;
        result = '0;
        for (int k = 0; k < c_MAX_SOURCES; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= 5'(num)) begin
                idx = idx - 5'(num);
            end
            if ((k < num) && !result.found && req[idx[c_MAX_IDX_W-1:0]]) begin
                result.found = 1'b1;
                result.index = idx[c_MAX_IDX_W-1:0];
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofs_plat_axi_stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : ofs_plat_axi_stream_out_reg
// Description : Single-entry registered output stage for an AXI stream.
//               Loads whenever the upstream beat is accepted and may be
//               drained and reloaded in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ofs_plat_axi_stream_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sink_tready,
    output logic             o_sink_tvalid,
    output logic [WIDTH-1:0] o_sink_data,
    output logic             o_can_accept
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Room exists when empty or when the held beat leaves this cycle.
    assign o_can_accept  = !r_valid || i_sink_tready;
    assign o_sink_tvalid = r_valid;
    assign o_sink_data   = r_data;

    // Load a new beat on accept; otherwise drop valid once drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_sink_tready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofs_plat_axi_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ofs_plat_axi_stream_rr_arbiter
// Description : Packet-granular round-robin merge of NUM_SOURCES AXI streams
//               into one registered stream. A grant is held from the first
//               beat until the owner's tlast beat is accepted, and the
//               source index travels with every beat on sink_tid.
// Revision    : 1.0 - initial release
// ============================================================================
module ofs_plat_axi_stream_rr_arbiter
    import ofs_plat_axi_stream_arb_pkg::*;
#(
    parameter  int NUM_SOURCES = 4,
    parameter  int TDATA_WIDTH = 512,
    parameter  int TUSER_WIDTH = 16,
    localparam int TID_WIDTH   = $clog2(NUM_SOURCES)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_SOURCES-1:0]             src_tvalid,
    output logic [NUM_SOURCES-1:0]             src_tready,
    input  logic [NUM_SOURCES-1:0]             src_tlast,
    input  logic [NUM_SOURCES*TDATA_WIDTH-1:0] src_tdata,
    input  logic [NUM_SOURCES*TUSER_WIDTH-1:0] src_tuser,
    output logic                               sink_tvalid,
    input  logic                               sink_tready,
    output logic                               sink_tlast,
    output logic [TDATA_WIDTH-1:0]             sink_tdata,
    output logic [TUSER_WIDTH-1:0]             sink_tuser,
    output logic [TID_WIDTH-1:0]               sink_tid,
    output logic                               pkt_active
);

    localparam int                   c_PAYLOAD_W = 1 + TUSER_WIDTH + TDATA_WIDTH + TID_WIDTH;
    localparam logic [TID_WIDTH-1:0] c_LAST_IDX  = TID_WIDTH'(NUM_SOURCES - 1);
    localparam logic [0:0]           c_ST_ARB    = 1'(ARB);
    localparam logic [0:0]           c_ST_LOCKED = 1'(LOCKED);

    logic [0:0]               r_state;
    logic [TID_WIDTH-1:0]     r_ptr;
    logic [TID_WIDTH-1:0]     r_owner;

    logic                     w_can_accept;
    logic [c_MAX_SOURCES-1:0] w_req_pad;
    logic [c_MAX_IDX_W-1:0]   w_ptr_pad;
    t_rr_pick                 w_pick;
    logic                     w_unused_pick;
    logic                     w_grant_valid;
    logic [TID_WIDTH-1:0]     w_grant;
    logic [NUM_SOURCES-1:0]   w_tready;
    logic                     w_accept;
    logic                     w_acc_last;
    logic [TDATA_WIDTH-1:0]   w_acc_data;
    logic [TUSER_WIDTH-1:0]   w_acc_user;
    logic [TID_WIDTH-1:0]     w_next_ptr;
    logic [c_PAYLOAD_W-1:0]   w_sink_payload;

    // Round-robin search over the valid sources starting at the pointer.
    always_comb begin
        w_req_pad                    = '0;
        w_req_pad[NUM_SOURCES-1:0]   = src_tvalid;
        w_ptr_pad                    = '0;
        w_ptr_pad[TID_WIDTH-1:0]     = r_ptr;
        w_pick                       = rr_pick(w_req_pad, w_ptr_pad, NUM_SOURCES);
    end

    // Only the low index bits matter for this NUM_SOURCES.
    assign w_unused_pick = &{1'b0, w_pick.index};

    // While locked the owner keeps the grant whether or not it is valid.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        if (r_state == c_ST_LOCKED) begin
            w_grant_valid = 1'b1;
            w_grant       = r_owner;
        end else begin
            w_grant_valid = w_pick.found;
            w_grant       = w_pick.index[TID_WIDTH-1:0];
        end
    end

    // One-hot ready to the granted source, suppressed while in reset.
    always_comb begin
        w_tready = '0;
        if (w_grant_valid && w_can_accept && !reset) begin
            w_tready[w_grant] = 1'b1;
        end
    end

    assign src_tready = w_tready;
    assign w_accept   = |(src_tvalid & w_tready);

    // Select the granted source's beat for the output register.
    always_comb begin
        w_acc_last = 1'b0;
        w_acc_data = '0;
        w_acc_user = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (TID_WIDTH'(i) == w_grant) begin
                w_acc_last = src_tlast[i];
                w_acc_data = src_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
                w_acc_user = src_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_grant == c_LAST_IDX) ? '0 : (w_grant + TID_WIDTH'(1));

    // Lock on a non-final beat; release and advance priority on tlast.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_accept) begin
            if (w_acc_last) begin
                r_state <= c_ST_ARB;
                r_ptr   <= w_next_ptr;
            end else begin
                r_state <= c_ST_LOCKED;
                r_owner <= w_grant;
            end
        end
    end

    assign pkt_active = (r_state == c_ST_LOCKED);

    ofs_plat_axi_stream_out_reg #(
        .WIDTH (c_PAYLOAD_W)
    ) u_out_reg (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_accept),
        .i_data        ({w_acc_last, w_acc_user, w_acc_data, w_grant}),
        .i_sink_tready (sink_tready),
        .o_sink_tvalid (sink_tvalid),
        .o_sink_data   (w_sink_payload),
        .o_can_accept  (w_can_accept)
    );

    assign {sink_tlast, sink_tuser, sink_tdata, sink_tid} = w_sink_payload;

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_axi_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofs_plat_axi_stream_rr_arbiter
// Description : Self-checking bench for the round-robin stream arbiter:
//               directed scenarios, a 3-source wrap check and a randomized
//               run against a behavioural model and per-source scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofs_plat_axi_stream_rr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int UW  = 8;
    localparam int TW  = 2;
    localparam int N3  = 3;
    localparam int DW3 = 8;
    localparam int UW3 = 4;

    logic clk = 1'b0;
    logic reset;

    logic [N-1:0]    src_tvalid, src_tready, src_tlast;
    logic [N*DW-1:0] src_tdata;
    logic [N*UW-1:0] src_tuser;
    logic            sink_tvalid, sink_tready, sink_tlast, pkt_active;
    logic [DW-1:0]   sink_tdata;
    logic [UW-1:0]   sink_tuser;
    logic [TW-1:0]   sink_tid;

    logic [N3-1:0]     b_src_tvalid, b_src_tready, b_src_tlast;
    logic [N3*DW3-1:0] b_src_tdata;
    logic [N3*UW3-1:0] b_src_tuser;
    logic              b_sink_tvalid, b_sink_tready, b_sink_tlast, b_pkt_active;
    logic [DW3-1:0]    b_sink_tdata;
    logic [UW3-1:0]    b_sink_tuser;
    logic [1:0]        b_sink_tid;

    int checks   = 0;
    int failures = 0;

    ofs_plat_axi_stream_rr_arbiter #(
        .NUM_SOURCES (N), .TDATA_WIDTH (DW), .TUSER_WIDTH (UW)
    ) dut (
        .clk (clk), .reset (reset),
        .src_tvalid (src_tvalid), .src_tready (src_tready), .src_tlast (src_tlast),
        .src_tdata (src_tdata), .src_tuser (src_tuser),
        .sink_tvalid (sink_tvalid), .sink_tready (sink_tready), .sink_tlast (sink_tlast),
        .sink_tdata (sink_tdata), .sink_tuser (sink_tuser), .sink_tid (sink_tid),
        .pkt_active (pkt_active)
    );

    ofs_plat_axi_stream_rr_arbiter #(
        .NUM_SOURCES (N3), .TDATA_WIDTH (DW3), .TUSER_WIDTH (UW3)
    ) dut3 (
        .clk (clk), .reset (reset),
        .src_tvalid (b_src_tvalid), .src_tready (b_src_tready), .src_tlast (b_src_tlast),
        .src_tdata (b_src_tdata), .src_tuser (b_src_tuser),
        .sink_tvalid (b_sink_tvalid), .sink_tready (b_sink_tready), .sink_tlast (b_sink_tlast),
        .sink_tdata (b_sink_tdata), .sink_tuser (b_sink_tuser), .sink_tid (b_sink_tid),
        .pkt_active (b_pkt_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [DW-1:0] d, input logic l);
        src_tdata[i*DW +: DW] = d;
        src_tuser[i*UW +: UW] = d[UW-1:0] ^ UW'(i);
        src_tlast[i]          = l;
        src_tvalid[i]         = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: expected output register, lock owner and next
    // priority source, plus per-source order and waiting-packet counts.
    // ------------------------------------------------------------------
    logic          sb_en = 1'b0;
    logic          m_valid, m_last, m_locked;
    logic [DW-1:0] m_data;
    logic [UW-1:0] m_user;
    int            m_tid, m_owner, m_ptr;
    int            next_seq [N];
    int            wait_pk  [N];

    initial begin : p_compare
        logic [N-1:0] exp_ready;
        logic         can;
        int           g, t, cand;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_sink_tvalid", sink_tvalid, 0);
                chk("rst_pkt_active", pkt_active, 0);
                chk("rst_src_tready", src_tready, 0);
                chk("rst_sink_tdata", sink_tdata, 0);
                m_valid = 0; m_last = 0; m_locked = 0; m_data = '0; m_user = '0;
                m_tid = 0; m_owner = 0; m_ptr = 0;
                for (int i = 0; i < N; i++) begin
                    next_seq[i] = 0;
                    wait_pk[i]  = 0;
                end
            end else begin
                chk("sink_tvalid", sink_tvalid, m_valid);
                chk("sink_tdata", sink_tdata, m_data);
                chk("sink_tuser", sink_tuser, m_user);
                chk("sink_tlast", sink_tlast, m_last);
                chk("sink_tid", sink_tid, m_tid);
                chk("pkt_active", pkt_active, m_locked);

                can       = !m_valid || sink_tready;
                exp_ready = '0;
                g         = -1;
                if (can) begin
                    if (m_locked) begin
                        g = m_owner;
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            cand = (m_ptr + k) % N;
                            if (g < 0 && src_tvalid[cand]) g = cand;
                        end
                    end
                    if (g >= 0) exp_ready[g] = 1'b1;
                end
                chk("src_tready", src_tready, exp_ready);

                if (sb_en && sink_tvalid && sink_tready) begin
                    t = int'(sink_tid);
                    chk("sb_order", sink_tdata[23:0], next_seq[t]);
                    chk("sb_src_field", sink_tdata[31:24], t);
                    next_seq[t]++;
                end

                for (int i = 0; i < N; i++) begin
                    if (!src_tvalid[i]) wait_pk[i] = 0;
                end

                if (g >= 0 && src_tvalid[g]) begin
                    m_valid    = 1;
                    m_data     = src_tdata[g*DW +: DW];
                    m_user     = src_tuser[g*UW +: UW];
                    m_last     = src_tlast[g];
                    m_tid      = g;
                    wait_pk[g] = 0;
                    if (src_tlast[g]) begin
                        m_locked = 0;
                        m_ptr    = (g + 1) % N;
                        for (int i = 0; i < N; i++) begin
                            if (sb_en && i != g && src_tvalid[i]) begin
                                wait_pk[i]++;
                                chk("starvation_wait", wait_pk[i] <= N - 1, 1);
                            end
                        end
                    end else begin
                        m_locked = 1;
                        m_owner  = g;
                    end
                end else if (sink_tready) begin
                    m_valid = 0;
                end
            end
        end
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Random driver state.
    int          rem [N];
    int          seq [N];
    logic [N-1:0] acc;
    logic        allow;
    int          guard;
    logic        busy;

    initial begin : p_main
        reset = 1'b1;
        src_tvalid = '0; src_tlast = '0; src_tdata = '0; src_tuser = '0;
        sink_tready = 1'b1;
        b_src_tvalid = '0; b_src_tlast = '0; b_src_tdata = '0; b_src_tuser = '0;
        b_sink_tready = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Single source 2, three beats.
        set_beat(2, 32'hA, 1'b0); step();
        chk("t1_data_a", sink_tdata, 32'hA); chk("t1_tid_a", sink_tid, 2); chk("t1_active_a", pkt_active, 1);
        set_beat(2, 32'hB, 1'b0); step();
        chk("t1_data_b", sink_tdata, 32'hB); chk("t1_tid_b", sink_tid, 2); chk("t1_active_b", pkt_active, 1);
        set_beat(2, 32'hC, 1'b1); step();
        chk("t1_data_c", sink_tdata, 32'hC); chk("t1_tid_c", sink_tid, 2);
        chk("t1_last_c", sink_tlast, 1); chk("t1_active_c", pkt_active, 0);
        src_tvalid[2] = 1'b0; step();
        chk("t1_drained", sink_tvalid, 0);

        // All four sources offering single-beat packets from reset.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < N; i++) set_beat(i, 32'h100 + i, 1'b1);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("t2_tid_seq", sink_tid, c % N);
            chk("t2_valid", sink_tvalid, 1);
        end
        src_tvalid = '0; step();

        // Source 0 four-beat packet; source 1 must wait.
        set_beat(0, 32'h200, 1'b0); step();
        chk("t3_tid0", sink_tid, 0); chk("t3_active", pkt_active, 1);
        set_beat(1, 32'h300, 1'b1);
        set_beat(0, 32'h201, 1'b0); #1;
        chk("t3_src1_blocked", src_tready[1], 0);
        step(); chk("t3_data1", sink_tdata, 32'h201);
        set_beat(0, 32'h202, 1'b0); step(); chk("t3_data2", sink_tdata, 32'h202);
        set_beat(0, 32'h203, 1'b1); #1;
        chk("t3_src1_blocked_last", src_tready[1], 0);
        step();
        chk("t3_data3", sink_tdata, 32'h203); chk("t3_tid3", sink_tid, 0); chk("t3_last3", sink_tlast, 1);
        src_tvalid[0] = 1'b0; #1;
        chk("t3_src1_granted", src_tready[1], 1);
        step();
        chk("t3_src1_data", sink_tdata, 32'h300); chk("t3_src1_tid", sink_tid, 1);
        src_tvalid[1] = 1'b0; step();

        // Five-cycle sink stall in the middle of a source-3 packet.
        for (int k = 0; k < 2; k++) begin
            set_beat(3, 32'h30 + k, 1'b0); step();
        end
        set_beat(3, 32'h32, 1'b0);
        sink_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t4_hold_data", sink_tdata, 32'h31);
            chk("t4_hold_valid", sink_tvalid, 1);
            chk("t4_src_tready", src_tready, 0);
        end
        sink_tready = 1'b1;
        for (int k = 2; k < 6; k++) begin
            set_beat(3, 32'h30 + k, k == 5); step();
            chk("t4_resume_data", sink_tdata, 32'h30 + k);
        end
        src_tvalid[3] = 1'b0; step();

        // Reset while locked on source 3 after moving the pointer to 2.
        set_beat(1, 32'h40, 1'b1); step();
        src_tvalid[1] = 1'b0;
        set_beat(3, 32'h50, 1'b0); step();
        set_beat(3, 32'h51, 1'b0); step();
        chk("t5_locked", pkt_active, 1);
        reset = 1'b1; src_tvalid = '0; #1;
        chk("t5_async_valid", sink_tvalid, 0);
        chk("t5_async_active", pkt_active, 0);
        step(); reset = 1'b0;
        step();
        chk("t5_post_valid", sink_tvalid, 0);
        chk("t5_post_active", pkt_active, 0);
        for (int i = 0; i < N; i++) set_beat(i, 32'h60 + i, 1'b1);
        step();
        chk("t5_ptr_zero", sink_tid, 0);
        src_tvalid = '0; step();

        // Three-source instance: pointer wraps from 2 back to 0.
        b_src_tdata  = {8'd2, 8'd1, 8'd0};
        b_src_tlast  = 3'b111;
        b_src_tvalid = 3'b111;
        for (int c = 0; c < 7; c++) begin
            step();
            chk("t6_wrap_tid", b_sink_tid, c % N3);
        end
        b_src_tvalid = '0; step();

        // Randomized traffic with random sink backpressure.
        reset = 1'b1; sb_en = 1'b1; allow = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        step(); reset = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc = src_tvalid & src_tready;
            @(posedge clk); #1;
            sink_tready = ($urandom_range(0, 99) < 75);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    rem[i]--;
                    seq[i]++;
                end
                if (rem[i] == 0 && allow && $urandom_range(0, 99) < 35) rem[i] = $urandom_range(1, 4);
                if (rem[i] > 0) set_beat(i, {8'(i), 24'(seq[i])}, rem[i] == 1);
                else            src_tvalid[i] = 1'b0;
            end
            if (cyc == 2999) allow = 1'b0;
        end

        // Drain everything still in flight.
        guard = 0;
        busy  = 1'b1;
        while (busy && guard < 200) begin
            @(negedge clk);
            acc = src_tvalid & src_tready;
            @(posedge clk); #1;
            sink_tready = 1'b1;
            busy = sink_tvalid;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    rem[i]--;
                    seq[i]++;
                end
                if (rem[i] > 0) begin
                    set_beat(i, {8'(i), 24'(seq[i])}, rem[i] == 1);
                    busy = 1'b1;
                end else begin
                    src_tvalid[i] = 1'b0;
                end
            end
            guard++;
        end
        chk("drain_within_bound", guard < 200, 1);
        step();
        for (int i = 0; i < N; i++) chk("sb_all_delivered", next_seq[i], seq[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
